// File: rtl/commit_trace_buffer_if.sv
// commit_trace_buffer_if
//   Bundles the writeback-stage commit port and the valid/ready drain port
//   of commit_trace_buffer.
//   master : the surrounding pipeline / trace consumer
//            (drives commit_* and out_ready; observes full and out_*)
//   slave  : commit_trace_buffer itself
//            (observes commit_* and out_ready; drives full and out_*)
interface commit_trace_buffer_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 32
);
  // commit side
  logic              commit_valid;
  logic [DATA_W-1:0] commit_pc;
  logic              commit_regwrite;
  logic [REG_W-1:0]  commit_wreg;
  logic [DATA_W-1:0] commit_wdata;
  logic              commit_memread;
  logic              commit_memwrite;
  logic [DATA_W-1:0] commit_maddr;
  logic [DATA_W-1:0] commit_mdata;
  logic              commit_halt;
  logic              full;
  // drain side
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_inum;
  logic [DATA_W-1:0] out_pc;
  logic              out_regwrite;
  logic [REG_W-1:0]  out_wreg;
  logic [DATA_W-1:0] out_wdata;
  logic              out_memread;
  logic              out_memwrite;
  logic [DATA_W-1:0] out_maddr;
  logic [DATA_W-1:0] out_mdata;
  logic              out_halt;

  modport master (
    output commit_valid, commit_pc, commit_regwrite, commit_wreg, commit_wdata,
           commit_memread, commit_memwrite, commit_maddr, commit_mdata, commit_halt,
           out_ready,
    input  full, out_valid, out_inum, out_pc, out_regwrite, out_wreg, out_wdata,
           out_memread, out_memwrite, out_maddr, out_mdata, out_halt
  );

  modport slave (
    input  commit_valid, commit_pc, commit_regwrite, commit_wreg, commit_wdata,
           commit_memread, commit_memwrite, commit_maddr, commit_mdata, commit_halt,
           out_ready,
    output full, out_valid, out_inum, out_pc, out_regwrite, out_wreg, out_wdata,
           out_memread, out_memwrite, out_maddr, out_mdata, out_halt
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer
//   Captures one retired-instruction record per cycle, tags it with a
//   0-based instruction number and queues it in a DEPTH-entry FIFO that is
//   drained over a valid/ready port. Also keeps instruction/cycle counters
//   and reports overflow, halt and drain completion.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus (slave)  commit_* record in, full out; out_valid/out_ready + out_* head
//   inst_count   number of accepted commits
//   cycle_count  cycles since reset, frozen once done
//   overflow     sticky: a commit was dropped because the FIFO was full
//   halted       a HALT record has been accepted; further commits ignored
//   done         halted and FIFO drained; held until reset
// Configuration:
//   COMMIT_TRACE_FILTER_EN  when defined, commits that write neither a
//   register nor memory and are not HALT are counted but not enqueued.
module commit_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  commit_trace_buffer_if.slave bus,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic             overflow,
  output logic             halted,
  output logic             done
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic              regwrite;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
    logic              memread;
    logic              memwrite;
    logic [DATA_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
    logic              halt;
  } rec_t;

  rec_t mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wrPtrReg, rdPtrReg, wrPtrNext, rdPtrNext;
  logic             fullReg, outValidReg, overflowReg, haltedReg, doneReg;
  logic             haltedNext;
  logic [CNT_W-1:0] instCountReg, cycleCountReg;
  logic             pop, live, enqueueable, push, countIt, drop;
  rec_t             newRec, headRec;

  always_comb begin
    pop  = outValidReg && bus.out_ready;
    live = bus.commit_valid && !haltedReg;
`ifdef COMMIT_TRACE_FILTER_EN
    enqueueable = bus.commit_regwrite || bus.commit_memwrite || bus.commit_halt;
`else
    enqueueable = 1'b1;
`endif
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    push    = live && enqueueable && (!fullReg || pop);
    drop    = live && enqueueable && fullReg && !pop;
    countIt = push || (live && !enqueueable);

    wrPtrNext  = wrPtrReg + {{AW{1'b0}}, push};
    rdPtrNext  = rdPtrReg + {{AW{1'b0}}, pop};
    haltedNext = haltedReg || (push && bus.commit_halt);

    newRec.inum     = instCountReg;
    newRec.pc       = bus.commit_pc;
    newRec.regwrite = bus.commit_regwrite;
    newRec.wreg     = bus.commit_wreg;
    newRec.wdata    = bus.commit_wdata;
    newRec.memread  = bus.commit_memread;
    newRec.memwrite = bus.commit_memwrite;
    newRec.maddr    = bus.commit_maddr;
    newRec.mdata    = bus.commit_mdata;
    newRec.halt     = bus.commit_halt;
  end

  // Storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wrPtrReg[AW-1:0]] <= newRec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrReg      <= '0;
      rdPtrReg      <= '0;
      fullReg       <= 1'b0;
      outValidReg   <= 1'b0;
      overflowReg   <= 1'b0;
      haltedReg     <= 1'b0;
      doneReg       <= 1'b0;
      instCountReg  <= '0;
      cycleCountReg <= '0;
    end else begin
      wrPtrReg    <= wrPtrNext;
      rdPtrReg    <= rdPtrNext;
      // Flags are computed from the post-update pointers so they describe
      // the occupancy after this cycle's push/pop.
      fullReg     <= (wrPtrNext[AW] != rdPtrNext[AW]) &&
                     (wrPtrNext[AW-1:0] == rdPtrNext[AW-1:0]);
      outValidReg <= (wrPtrNext != rdPtrNext);
      haltedReg   <= haltedNext;
      if (drop) overflowReg <= 1'b1;
      if (countIt) instCountReg <= instCountReg + 1'b1;
      if (!doneReg) cycleCountReg <= cycleCountReg + 1'b1;
      // Using next-state values makes done rise the cycle after the HALT
      // record is popped.
      doneReg <= doneReg || (haltedNext && (wrPtrNext == rdPtrNext));
    end
  end

  // Head fields read zero whenever nothing is queued (including after reset).
  assign headRec = outValidReg ? mem[rdPtrReg[AW-1:0]] : '0;

  assign bus.full         = fullReg;
  assign bus.out_valid    = outValidReg;
  assign bus.out_inum     = headRec.inum;
  assign bus.out_pc       = headRec.pc;
  assign bus.out_regwrite = headRec.regwrite;
  assign bus.out_wreg     = headRec.wreg;
  assign bus.out_wdata    = headRec.wdata;
  assign bus.out_memread  = headRec.memread;
  assign bus.out_memwrite = headRec.memwrite;
  assign bus.out_maddr    = headRec.maddr;
  assign bus.out_mdata    = headRec.mdata;
  assign bus.out_halt     = headRec.halt;

  assign inst_count  = instCountReg;
  assign cycle_count = cycleCountReg;
  assign overflow    = overflowReg;
  assign halted      = haltedReg;
  assign done        = doneReg;
endmodule

// File: tb/tb_commit_trace_buffer.sv
module tb_commit_trace_buffer;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = 32;

  typedef struct {
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic              regwrite;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
    logic              memread;
    logic              memwrite;
    logic [DATA_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
    logic              halt;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  logic [CNT_W-1:0] inst_count, cycle_count;
  logic overflow, halted, done;

  always #5 clk = ~clk;

  commit_trace_buffer_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  commit_trace_buffer #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .inst_count(inst_count), .cycle_count(cycle_count),
    .overflow(overflow), .halted(halted), .done(done)
  );

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: a queue of expected records plus plain counters.
  rec_t q[$];
  int unsigned mInst, mCyc;
  bit mOvf, mHalted, mDone;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t mk(input logic [15:0] pc, input bit rw, input bit mw, input bit hlt);
    rec_t r;
    r.inum = '0; r.pc = pc; r.regwrite = rw; r.wreg = pc[3:1];
    r.wdata = pc ^ 16'h5a5a; r.memread = 1'b0; r.memwrite = mw;
    r.maddr = pc + 16'h0100; r.mdata = ~pc; r.halt = hlt;
    return r;
  endfunction

  function automatic rec_t rnd();
    rec_t r;
    r.inum = '0; r.pc = DATA_W'($urandom); r.regwrite = 1'($urandom);
    r.wreg = REG_W'($urandom); r.wdata = DATA_W'($urandom);
    r.memread = 1'($urandom); r.memwrite = 1'($urandom);
    r.maddr = DATA_W'($urandom); r.mdata = DATA_W'($urandom); r.halt = 1'b0;
    return r;
  endfunction

  task automatic checkAll();
    check("out_valid", bus.out_valid, (q.size() > 0));
    check("full", bus.full, (q.size() == DEPTH));
    check("inst_count", inst_count, mInst);
    check("cycle_count", cycle_count, mCyc);
    check("overflow", overflow, mOvf);
    check("halted", halted, mHalted);
    check("done", done, mDone);
    if (q.size() > 0) begin
      check("out_inum", bus.out_inum, q[0].inum);
      check("out_pc", bus.out_pc, q[0].pc);
      check("out_regwrite", bus.out_regwrite, q[0].regwrite);
      check("out_wreg", bus.out_wreg, q[0].wreg);
      check("out_wdata", bus.out_wdata, q[0].wdata);
      check("out_memread", bus.out_memread, q[0].memread);
      check("out_memwrite", bus.out_memwrite, q[0].memwrite);
      check("out_maddr", bus.out_maddr, q[0].maddr);
      check("out_mdata", bus.out_mdata, q[0].mdata);
      check("out_halt", bus.out_halt, q[0].halt);
    end
  endtask

  // One clock cycle, entered and left at a negative edge: compare outputs,
  // drive this cycle's inputs, advance the model, then let the edge happen.
  task automatic step(input bit cv, input rec_t c, input bit rdy);
    bit pop, wasFull, enq, haltN;
    rec_t r;
    checkAll();
    bus.commit_valid    = cv;
    bus.commit_pc       = c.pc;
    bus.commit_regwrite = c.regwrite;
    bus.commit_wreg     = c.wreg;
    bus.commit_wdata    = c.wdata;
    bus.commit_memread  = c.memread;
    bus.commit_memwrite = c.memwrite;
    bus.commit_maddr    = c.maddr;
    bus.commit_mdata    = c.mdata;
    bus.commit_halt     = c.halt;
    bus.out_ready       = rdy;

    pop     = (q.size() > 0) && rdy;
    wasFull = (q.size() == DEPTH);
    haltN   = mHalted;
    if (pop) begin
      $display("pop  inum=%0d pc=%h halt=%0d", q[0].inum, q[0].pc, q[0].halt);
      void'(q.pop_front());
    end
`ifdef COMMIT_TRACE_FILTER_EN
    enq = c.regwrite || c.memwrite || c.halt;
`else
    enq = 1'b1;
`endif
    if (cv && !mHalted) begin
      if (!enq) begin
        mInst++;
      end else if (wasFull && !pop) begin
        mOvf = 1'b1;
        $display("drop pc=%h", c.pc);
      end else begin
        r = c;
        r.inum = CNT_W'(mInst);
        q.push_back(r);
        mInst++;
        if (c.halt) haltN = 1'b1;
      end
    end
    if (!mDone) mCyc++;
    mDone   = mDone || (haltN && q.size() == 0);
    mHalted = haltN;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.commit_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mInst = 0; mCyc = 0; mOvf = 0; mHalted = 0; mDone = 0;
  endtask

  rec_t idle;

  initial begin
    idle = mk(16'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    bus.commit_valid = 1'b0; bus.commit_pc = '0; bus.commit_regwrite = 1'b0;
    bus.commit_wreg = '0; bus.commit_wdata = '0; bus.commit_memread = 1'b0;
    bus.commit_memwrite = 1'b0; bus.commit_maddr = '0; bus.commit_mdata = '0;
    bus.commit_halt = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    doReset();

    // Reset state, including zeroed head fields.
    check("reset_out_inum", bus.out_inum, 0);
    check("reset_out_pc", bus.out_pc, 0);
    check("reset_out_wdata", bus.out_wdata, 0);
    check("reset_out_halt", bus.out_halt, 0);

    // Three in-order commits drained immediately.
    step(1, mk(16'h0000, 1, 0, 0), 1);
    step(1, mk(16'h0002, 1, 0, 0), 1);
    step(1, mk(16'h0004, 1, 0, 0), 1);
    for (int i = 0; i < 3; i++) step(0, idle, 1);
    check("inst_count_3", inst_count, 3);

    // Fill with consumer stalled: ninth commit overflows.
    doReset();
    for (int i = 0; i < 9; i++) step(1, mk(16'(2 * i), 1, 0, 0), 0);
    check("full_after_9", bus.full, 1);
    check("overflow_after_9", overflow, 1);
    check("inst_count_8", inst_count, 8);
    check("first_head_inum", bus.out_inum, 0);
    step(0, idle, 1);

    // Push and pop together while full: accepted, still full, no overflow.
    doReset();
    for (int i = 0; i < 8; i++) step(1, mk(16'(16'h40 + 2 * i), 1, 1, 0), 0);
    step(1, mk(16'h0060, 1, 0, 0), 1);
    check("full_pushpop", bus.full, 1);
    check("overflow_pushpop", overflow, 0);
    for (int i = 0; i < 10; i++) step(0, idle, 1);

    // Alternating ready with back-to-back commits, then random traffic.
    for (int i = 0; i < 40; i++) step(1, rnd(), 1'(i % 2));
    for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, rnd(), 1'($urandom));
    for (int i = 0; i < 4; i++) step(1, rnd(), 0);

    // Reset with records still buffered, then HALT sequence.
    doReset();
    step(1, mk(16'h000c, 1, 0, 0), 1);
    step(1, mk(16'h000e, 0, 1, 0), 1);
    step(1, mk(16'h0010, 0, 0, 1), 1);
    step(1, mk(16'h0012, 1, 0, 0), 1);
    step(1, mk(16'h0014, 1, 0, 0), 1);
    for (int i = 0; i < 6; i++) step(0, idle, 1);
    check("halt_halted", halted, 1);
    check("halt_done", done, 1);
    check("halt_inst_count", inst_count, 3);

`ifdef COMMIT_TRACE_FILTER_EN
    // Filtered commits are counted but never emitted.
    doReset();
    step(1, mk(16'h0020, 0, 0, 0), 1);
    step(1, mk(16'h0022, 1, 0, 0), 1);
    check("filter_head_inum", bus.out_inum, 1);
    step(1, mk(16'h0024, 0, 0, 0), 1);
    for (int i = 0; i < 3; i++) step(0, idle, 1);
    check("filter_inst_count", inst_count, 3);
`endif

    checkAll();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
